programador_campos: RTL and testbench
=====================================

PROGRAMADOR_CAMPOS -- requirements
Module: programador_campos

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-low.
REQ-003 SHALL have ports prog_fecha, prog_hora, prog_timer, inputs, 1 bit each: mode request flags, at most one high.
REQ-004 SHALL have ports btn_arriba, btn_abajo, btn_izq, btn_der, inputs, 1 bit each: debounced, synchronized button levels.
REQ-005 SHALL have port dato_actual, input, 24 bits: current BCD value {alto[23:16], medio[15:8], bajo[7:0]} of the selected register set.
REQ-006 SHALL have ports campo_alto, campo_medio, campo_bajo, outputs, 8 bits each: edited BCD fields.
REQ-007 SHALL have port cursor, output, 2 bits: selected field (0 = bajo, 1 = medio, 2 = alto).
REQ-008 SHALL have port modo, output, 2 bits: 00 idle, 01 timer, 10 hora, 11 fecha.
REQ-009 SHALL have port escribir, output, 1 bit: one-cycle commit strobe.
REQ-010 SHALL have port destino, output, 2 bits: mode code of the committed set, valid while escribir = 1.

Function
REQ-011 SHALL implement states REPOSO, EDITA, COMMIT.
REQ-012 In REPOSO, exactly one flag high SHALL cause a transition to EDITA, load the fields from dato_actual, set cursor = 0 and set modo per REQ-008; zero or multiple flags SHALL leave the block in REPOSO.
REQ-013 In EDITA, the active flag dropping or a different flag rising SHALL cause a transition to COMMIT, with fields frozen.
REQ-014 COMMIT SHALL last exactly one cycle: escribir = 1 and destino = modo; the next state SHALL be REPOSO with modo = 00 and fields held.
REQ-015 A new flag present in the COMMIT cycle SHALL be serviced from REPOSO on the following cycle, so the minimum gap between commit and new entry is 1 cycle.
REQ-016 Buttons SHALL act only on a rising edge, detected against a one-cycle-delayed copy; a held button SHALL produce one action.
REQ-017 The edge registers SHALL update every cycle in all states, so an edge that occurs outside EDITA is consumed and discarded.
REQ-018 btn_der SHALL step the cursor 0->1->2->0; btn_izq SHALL step it 0->2->1->0; simultaneous izq and der edges SHALL leave the cursor unchanged.
REQ-019 btn_arriba SHALL increment the selected field in BCD, wrapping max->min; btn_abajo SHALL decrement it, wrapping min->max; simultaneous edges SHALL leave the field unchanged.
REQ-020 A cursor edge and a value edge in the same cycle SHALL apply the value change to the old cursor position and then move the cursor.
REQ-021 Field ranges SHALL be:
  - hora and timer: alto 00-23, medio 00-59, bajo 00-59.
  - fecha: alto 01-31 (day), medio 01-12 (month), bajo 00-99 (year).
REQ-022 An increment from an out-of-range or non-BCD loaded value SHALL yield min, and a decrement SHALL yield max.
REQ-023 BCD arithmetic SHALL operate per nibble; a low nibble of 9 on increment SHALL carry into the high nibble; no binary overflow SHALL be visible.
REQ-024 Field changes SHALL appear on the outputs 1 cycle after the button edge is sampled.
REQ-025 Outside EDITA, the fields SHALL ignore buttons and hold their last value.

Reset
REQ-026 With reset = 0 at a clock edge, the block SHALL enter REPOSO and set fields = 00, cursor = 0, modo = 00, escribir = 0, destino = 00, and edge registers = 0.
REQ-027 Reset asserted during EDITA SHALL abort editing without an escribir pulse.
REQ-028 Reset SHALL dominate all other inputs in the same cycle.

Verification
REQ-029 Bench SHALL cover: prog_hora rises with dato_actual = 23_59_58 -> modo = 10, fields 23/59/58, cursor = 0; two arriba edges -> bajo = 59, then 00.
REQ-030 Bench SHALL cover: fecha mode, cursor at alto = 01, abajo edge -> 31; cursor at medio = 12, arriba edge -> 01.
REQ-031 Bench SHALL cover: arriba held 10 cycles -> exactly one increment; arriba and abajo rising in the same cycle -> no change.
REQ-032 Bench SHALL cover: prog_timer drops -> escribir high exactly 1 cycle with destino = 01 and fields stable, then modo = 00.
REQ-033 Bench SHALL cover: prog_hora directly replaced by prog_fecha -> COMMIT with destino = 10, 1 cycle REPOSO, then EDITA with modo = 11 and fields reloaded.
REQ-034 Bench SHALL cover: reset = 0 mid-edit -> all outputs zero next cycle, no escribir; loaded value 0x7A then arriba -> min value.

Source files
------------

// File: rtl/programador_campos.sv
// Field editor for date / time / timer register sets. It loads a BCD triple,
// lets the buttons move a cursor and step fields within range, and then issues a one-cycle commit.
module programador_campos (
  input  logic        clk,
  input  logic        reset,
  input  logic        prog_fecha,
  input  logic        prog_hora,
  input  logic        prog_timer,
  input  logic        btn_arriba,
  input  logic        btn_abajo,
  input  logic        btn_izq,
  input  logic        btn_der,
  input  logic [23:0] dato_actual,
  output logic [7:0]  campo_alto,
  output logic [7:0]  campo_medio,
  output logic [7:0]  campo_bajo,
  output logic [1:0]  cursor,
  output logic [1:0]  modo,
  output logic        escribir,
  output logic [1:0]  destino,
  output logic [1:0]  estado_dbg
);

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    EDITA  = 2'd1,
    COMMIT = 2'd2
  } estado_t;

  localparam logic [1:0] MODO_IDLE  = 2'b00;
  localparam logic [1:0] MODO_TIMER = 2'b01;
  localparam logic [1:0] MODO_HORA  = 2'b10;
  localparam logic [1:0] MODO_FECHA = 2'b11;

  localparam logic [1:0] CUR_BAJO  = 2'd0;
  localparam logic [1:0] CUR_MEDIO = 2'd1;
  localparam logic [1:0] CUR_ALTO  = 2'd2;

  estado_t    estado_q, estado_d;
  logic [7:0] alto_q, alto_d;
  logic [7:0] medio_q, medio_d;
  logic [7:0] bajo_q, bajo_d;
  logic [1:0] cursor_q, cursor_d;
  logic [1:0] modo_q, modo_d;
  logic [1:0] destino_q, destino_d;
  logic       escribir_q, escribir_d;
  logic [3:0] btn_prev_q, btn_prev_d;

  logic [3:0] btn_now;
  logic [3:0] btn_rise;
  logic       sube, baja, mueve_der, mueve_izq;
  logic       flag_unico;
  logic [1:0] modo_pedido;
  logic       salir;
  logic [7:0] campo_sel, campo_nuevo;
  logic [7:0] lim_min, lim_max;

  function automatic logic es_bcd(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Invalid or out-of-range values snap to min on increment.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                         input logic [7:0] lo,
                                         input logic [7:0] hi);
    logic [7:0] r;
    if (!es_bcd(v) || (v < lo) || (v >= hi))
      r = lo;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Invalid or out-of-range values snap to max on decrement.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v,
                                         input logic [7:0] lo,
                                         input logic [7:0] hi);
    logic [7:0] r;
    if (!es_bcd(v) || (v <= lo) || (v > hi))
      r = hi;
    else if (v[3:0] == 4'd0)
      r = {v[7:4] - 4'd1, 4'd9};
    else
      r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  assign btn_now   = {btn_arriba, btn_abajo, btn_izq, btn_der};
  assign btn_rise  = btn_now & ~btn_prev_q;
  assign sube      = btn_rise[3] & ~btn_rise[2];
  assign baja      = btn_rise[2] & ~btn_rise[3];
  assign mueve_izq = btn_rise[1] & ~btn_rise[0];
  assign mueve_der = btn_rise[0] & ~btn_rise[1];

  always_comb begin
    flag_unico  = 1'b1;
    modo_pedido = MODO_IDLE;
    case ({prog_fecha, prog_hora, prog_timer})
      3'b100:  modo_pedido = MODO_FECHA;
      3'b010:  modo_pedido = MODO_HORA;
      3'b001:  modo_pedido = MODO_TIMER;
      default: flag_unico  = 1'b0;
    endcase
  end

  // Leave editing when the owning flag drops or any other flag shows up.
  always_comb begin
    salir = 1'b1;
    case (modo_q)
      MODO_TIMER: salir = !prog_timer || prog_hora  || prog_fecha;
      MODO_HORA:  salir = !prog_hora  || prog_timer || prog_fecha;
      MODO_FECHA: salir = !prog_fecha || prog_timer || prog_hora;
      default:    salir = 1'b1;
    endcase
  end

  always_comb begin
    lim_min = 8'h00;
    lim_max = 8'h59;
    case (cursor_q)
      CUR_ALTO: begin
        if (modo_q == MODO_FECHA) begin
          lim_min = 8'h01;
          lim_max = 8'h31;
        end else begin
          lim_min = 8'h00;
          lim_max = 8'h23;
        end
      end
      CUR_MEDIO: begin
        if (modo_q == MODO_FECHA) begin
          lim_min = 8'h01;
          lim_max = 8'h12;
        end else begin
          lim_min = 8'h00;
          lim_max = 8'h59;
        end
      end
      default: begin
        if (modo_q == MODO_FECHA) begin
          lim_min = 8'h00;
          lim_max = 8'h99;
        end else begin
          lim_min = 8'h00;
          lim_max = 8'h59;
        end
      end
    endcase
  end

  always_comb begin
    case (cursor_q)
      CUR_ALTO:  campo_sel = alto_q;
      CUR_MEDIO: campo_sel = medio_q;
      default:   campo_sel = bajo_q;
    endcase
    if (sube)
      campo_nuevo = bcd_inc(campo_sel, lim_min, lim_max);
    else if (baja)
      campo_nuevo = bcd_dec(campo_sel, lim_min, lim_max);
    else
      campo_nuevo = campo_sel;
  end

  // Commit port: destino is meaningful only while escribir is high. The strobe
  // lasts a single cycle and has no backpressure, so the consumer must take it then.
  always_comb begin
    estado_d   = estado_q;
    alto_d     = alto_q;
    medio_d    = medio_q;
    bajo_d     = bajo_q;
    cursor_d   = cursor_q;
    modo_d     = modo_q;
    escribir_d = 1'b0;
    destino_d  = MODO_IDLE;
    btn_prev_d = btn_now;
    case (estado_q)
      REPOSO: begin
        if (flag_unico) begin
          estado_d = EDITA;
          alto_d   = dato_actual[23:16];
          medio_d  = dato_actual[15:8];
          bajo_d   = dato_actual[7:0];
          cursor_d = CUR_BAJO;
          modo_d   = modo_pedido;
        end
      end
      EDITA: begin
        if (salir) begin
          estado_d   = COMMIT;
          escribir_d = 1'b1;
          destino_d  = modo_q;
        end else begin
          case (cursor_q)
            CUR_ALTO:  alto_d  = campo_nuevo;
            CUR_MEDIO: medio_d = campo_nuevo;
            default:   bajo_d  = campo_nuevo;
          endcase
          if (mueve_der)
            cursor_d = (cursor_q == CUR_ALTO) ? CUR_BAJO : cursor_q + 2'd1;
          else if (mueve_izq)
            cursor_d = (cursor_q == CUR_BAJO) ? CUR_ALTO : cursor_q - 2'd1;
        end
      end
      COMMIT: begin
        estado_d = REPOSO;
        modo_d   = MODO_IDLE;
      end
      default: begin
        estado_d = REPOSO;
        modo_d   = MODO_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_q   <= REPOSO;
      alto_q     <= 8'h00;
      medio_q    <= 8'h00;
      bajo_q     <= 8'h00;
      cursor_q   <= CUR_BAJO;
      modo_q     <= MODO_IDLE;
      escribir_q <= 1'b0;
      destino_q  <= MODO_IDLE;
      btn_prev_q <= 4'b0000;
    end else begin
      estado_q   <= estado_d;
      alto_q     <= alto_d;
      medio_q    <= medio_d;
      bajo_q     <= bajo_d;
      cursor_q   <= cursor_d;
      modo_q     <= modo_d;
      escribir_q <= escribir_d;
      destino_q  <= destino_d;
      btn_prev_q <= btn_prev_d;
    end
  end

  assign campo_alto  = alto_q;
  assign campo_medio = medio_q;
  assign campo_bajo  = bajo_q;
  assign cursor      = cursor_q;
  assign modo        = modo_q;
  assign escribir    = escribir_q;
  assign destino     = destino_q;
  assign estado_dbg  = estado_q;

endmodule

// File: tb/tb_programador_campos.sv
// Bench for programador_campos: directed scenarios with literal expectations, then
// random flags/buttons/data checked every cycle against a decimal-arithmetic model.
module tb_programador_campos;

  logic        clk = 1'b0;
  logic        reset;
  logic        prog_fecha, prog_hora, prog_timer;
  logic        btn_arriba, btn_abajo, btn_izq, btn_der;
  logic [23:0] dato_actual;
  logic [7:0]  campo_alto, campo_medio, campo_bajo;
  logic [1:0]  cursor, modo, destino, estado_dbg;
  logic        escribir;

  programador_campos dut (
    .clk         (clk),
    .reset       (reset),
    .prog_fecha  (prog_fecha),
    .prog_hora   (prog_hora),
    .prog_timer  (prog_timer),
    .btn_arriba  (btn_arriba),
    .btn_abajo   (btn_abajo),
    .btn_izq     (btn_izq),
    .btn_der     (btn_der),
    .dato_actual (dato_actual),
    .campo_alto  (campo_alto),
    .campo_medio (campo_medio),
    .campo_bajo  (campo_bajo),
    .cursor      (cursor),
    .modo        (modo),
    .escribir    (escribir),
    .destino     (destino),
    .estado_dbg  (estado_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_campo [3];   // 0 bajo, 1 medio, 2 alto
  int         m_cur, m_modo, m_dest;
  bit         m_edit, m_commit, started;
  logic [3:0] m_prev;

  function automatic logic [7:0] step(input logic [7:0] v, input int md, input int idx, input bit up);
    int lo, hi, n;
    bit ok;
    if (md == 3) begin
      if (idx == 2)      begin lo = 1; hi = 31; end
      else if (idx == 1) begin lo = 1; hi = 12; end
      else               begin lo = 0; hi = 99; end
    end else begin
      lo = 0;
      hi = (idx == 2) ? 23 : 59;
    end
    ok = (v[7:4] < 4'd10) && (v[3:0] < 4'd10);
    n  = int'(v[7:4]) * 10 + int'(v[3:0]);
    if (up) n = (!ok || n < lo || n >= hi) ? lo : n + 1;
    else    n = (!ok || n <= lo || n > hi) ? hi : n - 1;
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  always @(posedge clk) begin
    logic [3:0] b, r;
    int nflag;
    bit activo;
    b = {btn_arriba, btn_abajo, btn_izq, btn_der};
    nflag = int'(prog_fecha) + int'(prog_hora) + int'(prog_timer);
    if (!reset) begin
      for (int k = 0; k < 3; k++) m_campo[k] = 8'h00;
      m_cur = 0; m_modo = 0; m_dest = 0; m_edit = 0; m_commit = 0; m_prev = 4'b0;
    end else begin
      r = b & ~m_prev;
      m_prev = b;
      if (m_commit) begin
        m_commit = 0; m_modo = 0; m_dest = 0;
      end else if (!m_edit) begin
        if (nflag == 1) begin
          m_edit = 1;
          m_modo = prog_fecha ? 3 : (prog_hora ? 2 : 1);
          m_campo[2] = dato_actual[23:16];
          m_campo[1] = dato_actual[15:8];
          m_campo[0] = dato_actual[7:0];
          m_cur = 0;
        end
      end else begin
        activo = (m_modo == 3) ? prog_fecha : ((m_modo == 2) ? prog_hora : prog_timer);
        if (!activo || nflag > 1) begin
          m_edit = 0; m_commit = 1; m_dest = m_modo;
        end else begin
          if (r[3] && !r[2])      m_campo[m_cur] = step(m_campo[m_cur], m_modo, m_cur, 1'b1);
          else if (r[2] && !r[3]) m_campo[m_cur] = step(m_campo[m_cur], m_modo, m_cur, 1'b0);
          if (r[0] && !r[1])      m_cur = (m_cur + 1) % 3;
          else if (r[1] && !r[0]) m_cur = (m_cur + 2) % 3;
        end
      end
    end
    started = 1;
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  always @(negedge clk) begin
    if (started)
      check("salidas", {campo_alto, campo_medio, campo_bajo, cursor, modo, escribir, destino},
            {m_campo[2], m_campo[1], m_campo[0], 2'(m_cur), 2'(m_modo), m_commit, 2'(m_dest)});
  end

  function automatic logic [7:0] rbcd();
    int n;
    n = $urandom_range(0, 99);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  // ---------------- driver ----------------
  initial begin
    reset = 1'b0;
    {prog_fecha, prog_hora, prog_timer} = 3'b000;
    {btn_arriba, btn_abajo, btn_izq, btn_der} = 4'b0000;
    dato_actual = 24'h0;

    check("modelo_inc_59", step(8'h59, 2, 0, 1'b1), 8'h00);
    check("modelo_dec_dia", step(8'h01, 3, 2, 1'b0), 8'h31);
    check("modelo_inc_7a", step(8'h7A, 1, 0, 1'b1), 8'h00);

    tick(2);
    check("reset_ceros", {campo_alto, campo_medio, campo_bajo, cursor, modo, escribir, destino}, 33'h0);

    // hora entry and bajo wrap
    reset = 1'b1; prog_hora = 1'b1; dato_actual = 24'h235958;
    tick();
    check("hora_carga", {campo_alto, campo_medio, campo_bajo, cursor, modo}, {8'h23, 8'h59, 8'h58, 2'd0, 2'b10});
    btn_arriba = 1'b1; tick();
    check("hora_bajo_59", campo_bajo, 8'h59);
    btn_arriba = 1'b0; tick();
    btn_arriba = 1'b1; tick();
    check("hora_bajo_00", campo_bajo, 8'h00);
    btn_arriba = 1'b0; tick();
    btn_arriba = 1'b1; tick(10);
    check("mantenido_un_paso", campo_bajo, 8'h01);
    btn_arriba = 1'b0; tick();
    btn_arriba = 1'b1; btn_abajo = 1'b1; tick();
    check("arriba_abajo_juntos", campo_bajo, 8'h01);
    btn_arriba = 1'b0; btn_abajo = 1'b0; tick();
    btn_izq = 1'b1; btn_der = 1'b1; tick();
    check("izq_der_juntos", cursor, 2'd0);
    btn_izq = 1'b0; btn_der = 1'b0; tick();

    // hora replaced directly by fecha
    prog_hora = 1'b0; prog_fecha = 1'b1; dato_actual = 24'h011299;
    tick();
    check("commit_hora", {escribir, destino, modo, campo_alto, campo_medio, campo_bajo},
          {1'b1, 2'b10, 2'b10, 8'h23, 8'h59, 8'h01});
    tick();
    check("reposo_tras_commit", {escribir, modo, campo_bajo}, {1'b0, 2'b00, 8'h01});
    tick();
    check("fecha_carga", {campo_alto, campo_medio, campo_bajo, cursor, modo}, {8'h01, 8'h12, 8'h99, 2'd0, 2'b11});
    btn_izq = 1'b1; tick();
    check("cursor_izq_0_2", cursor, 2'd2);
    btn_izq = 1'b0; tick();
    btn_abajo = 1'b1; tick();
    check("dia_01_a_31", campo_alto, 8'h31);
    btn_abajo = 1'b0; tick();
    btn_izq = 1'b1; tick();
    check("cursor_izq_2_1", cursor, 2'd1);
    btn_izq = 1'b0; tick();
    btn_arriba = 1'b1; tick();
    check("mes_12_a_01", campo_medio, 8'h01);
    btn_arriba = 1'b0; tick();
    btn_arriba = 1'b1; btn_der = 1'b1; tick();
    check("valor_y_cursor", {campo_medio, cursor}, {8'h02, 2'd2});
    btn_arriba = 1'b0; btn_der = 1'b0; tick();
    prog_fecha = 1'b0; tick(2);

    // timer with a non-BCD loaded value, then commit
    prog_timer = 1'b1; dato_actual = 24'h12347A;
    tick();
    check("timer_carga", {modo, campo_bajo}, {2'b01, 8'h7A});
    btn_arriba = 1'b1; tick();
    check("no_bcd_inc_min", campo_bajo, 8'h00);
    btn_arriba = 1'b0; tick();
    prog_timer = 1'b0; tick();
    check("commit_timer", {escribir, destino, modo, campo_alto, campo_medio, campo_bajo},
          {1'b1, 2'b01, 2'b01, 8'h12, 8'h34, 8'h00});
    tick();
    check("timer_fin", {escribir, destino, modo, campo_alto, campo_medio, campo_bajo},
          {1'b0, 2'b00, 2'b00, 8'h12, 8'h34, 8'h00});

    // out-of-range decrement, then reset mid-edit
    prog_hora = 1'b1; dato_actual = 24'h7A3000;
    tick();
    btn_izq = 1'b1; tick();
    btn_izq = 1'b0; tick();
    btn_abajo = 1'b1; tick();
    check("no_bcd_dec_max", campo_alto, 8'h23);
    btn_abajo = 1'b0; tick();
    btn_arriba = 1'b1; reset = 1'b0; tick();
    check("reset_en_edicion", {campo_alto, campo_medio, campo_bajo, cursor, modo, escribir, destino}, 33'h0);
    reset = 1'b1; tick();
    check("reentrada_sin_escribir", {escribir, modo, campo_alto, campo_bajo}, {1'b0, 2'b10, 8'h7A, 8'h00});
    btn_arriba = 1'b0; prog_hora = 1'b0; tick(2);

    // random phase
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 6))
          0:       {prog_fecha, prog_hora, prog_timer} = 3'b000;
          1:       {prog_fecha, prog_hora, prog_timer} = 3'b100;
          2:       {prog_fecha, prog_hora, prog_timer} = 3'b010;
          3:       {prog_fecha, prog_hora, prog_timer} = 3'b001;
          4:       {prog_fecha, prog_hora, prog_timer} = 3'b110;
          5:       {prog_fecha, prog_hora, prog_timer} = 3'b011;
          default: {prog_fecha, prog_hora, prog_timer} = 3'b111;
        endcase
      end
      if ($urandom_range(0, 3) == 0) btn_arriba = ~btn_arriba;
      if ($urandom_range(0, 3) == 0) btn_abajo  = ~btn_abajo;
      if ($urandom_range(0, 4) == 0) btn_izq    = ~btn_izq;
      if ($urandom_range(0, 4) == 0) btn_der    = ~btn_der;
      if ($urandom_range(0, 7) == 0)
        dato_actual = ($urandom_range(0, 1) == 1) ? {rbcd(), rbcd(), rbcd()} : 24'($urandom);
      tick();
    end

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
